// File: rtl/snn_delay_layer.sv
// snn_delay_layer: one fully connected layer of leaky integrate-and-fire neurons
// with per-synapse axonal delays, configured through a byte-wide write port.
module snn_delay_layer #(
    parameter int N_IN    = 4,
    parameter int N_OUT   = 2,
    parameter int DELAY_W = 2,
    parameter int V_W     = 12
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic [7:0]       cfg_addr,
    input  logic [7:0]       cfg_wdata,
    input  logic             input_ready,
    input  logic [N_IN-1:0]  input_spikes,
    output logic             busy,
    output logic [N_OUT-1:0] output_spikes,
    output logic             data_valid_out,
    output logic [7:0]       debug_output
);

    localparam int N  = N_IN * N_OUT;
    localparam int D  = 1 << DELAY_W;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] S_LAST    = SW'(N - 1);
    localparam logic [7:0]    ADDR_THR  = 8'(2 * N);
    localparam logic [7:0]    ADDR_LEAK = 8'(2 * N + 1);
    localparam logic signed [V_W-1:0] V_MAX = {1'b0, {(V_W-1){1'b1}}};
    localparam logic signed [V_W-1:0] V_MIN = {1'b1, {(V_W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACCUM, FIRE} state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      s_q, s_d;
    logic               do_load, do_accum, do_fire;

    logic [7:0]         weight_q [N];
    logic [DELAY_W-1:0] delay_q  [N];
    logic [7:0]         thr_q;
    logic [2:0]         leak_q;
    logic [N_IN-1:0]    hist_q   [D];
    logic signed [V_W-1:0] v_q   [N_OUT];
    logic signed [V_W-1:0] acc_q [N_OUT];
    logic [N_OUT-1:0]   spk_q;
    logic               dv_q;

    logic               cfg_ok;
    logic [2:0]         leak_eff;
    logic               contrib;
    int                 cur_i, cur_j;
    logic signed [V_W-1:0] thr_ext;

    function automatic logic signed [V_W-1:0] sat_add(input logic signed [V_W-1:0] a,
                                                      input logic signed [7:0]     b);
        logic signed [V_W:0] sum;
        sum = {a[V_W-1], a} + {{(V_W-7){b[7]}}, b};
        if (sum[V_W] != sum[V_W-1])
            return sum[V_W] ? V_MIN : V_MAX;
        return sum[V_W-1:0];
    endfunction

    // Shift of zero means "no leak", not "leak everything".
    function automatic logic signed [V_W-1:0] leak_load(input logic signed [V_W-1:0] v,
                                                        input logic [2:0]            sh);
        if (sh == 3'd0)
            return v;
        return v - (v >>> sh);
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            s_q     <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        s_d      = s_q;
        do_load  = 1'b0;
        do_accum = 1'b0;
        do_fire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (input_ready) begin
                    do_load = 1'b1;
                    s_d     = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                do_accum = 1'b1;
                if (s_q == S_LAST)
                    state_d = FIRE;
                else
                    s_d = s_q + SW'(1);
            end
            FIRE: begin
                do_fire = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A leak write in the same cycle as the load takes effect for that load.
    always_comb begin
        cfg_ok   = cfg_we && (state_q == IDLE);
        leak_eff = (cfg_ok && cfg_addr == ADDR_LEAK) ? cfg_wdata[2:0] : leak_q;
        cur_i    = int'(s_q) % N_IN;
        cur_j    = int'(s_q) / N_IN;
        contrib  = 1'b0;
        for (int i = 0; i < N_IN; i++)
            if (cur_i == i)
                contrib = hist_q[delay_q[s_q]][i];
        thr_ext  = $signed({{(V_W-8){1'b0}}, thr_q});
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int s = 0; s < N; s++) begin
                weight_q[s] <= '0;
                delay_q[s]  <= '0;
            end
            thr_q  <= 8'h40;
            leak_q <= '0;
            for (int d = 0; d < D; d++)
                hist_q[d] <= '0;
            for (int j = 0; j < N_OUT; j++) begin
                v_q[j]   <= '0;
                acc_q[j] <= '0;
            end
            spk_q <= '0;
            dv_q  <= 1'b0;
        end else begin
            dv_q <= 1'b0;
            if (cfg_ok) begin
                for (int s = 0; s < N; s++) begin
                    if (cfg_addr == 8'(s))
                        weight_q[s] <= cfg_wdata;
                    if (cfg_addr == 8'(N + s))
                        delay_q[s] <= cfg_wdata[DELAY_W-1:0];
                end
                if (cfg_addr == ADDR_THR)
                    thr_q <= cfg_wdata;
                if (cfg_addr == ADDR_LEAK)
                    leak_q <= cfg_wdata[2:0];
            end
            if (do_load) begin
                hist_q[0] <= input_spikes;
                for (int d = 1; d < D; d++)
                    hist_q[d] <= hist_q[d-1];
                for (int j = 0; j < N_OUT; j++)
                    acc_q[j] <= leak_load(v_q[j], leak_eff);
            end
            if (do_accum && contrib) begin
                for (int j = 0; j < N_OUT; j++)
                    if (cur_j == j)
                        acc_q[j] <= sat_add(acc_q[j], weight_q[s_q]);
            end
            if (do_fire) begin
                for (int j = 0; j < N_OUT; j++) begin
                    if (acc_q[j] >= thr_ext) begin
                        spk_q[j] <= 1'b1;
                        v_q[j]   <= '0;
                    end else begin
                        spk_q[j] <= 1'b0;
                        v_q[j]   <= acc_q[j];
                    end
                end
                dv_q <= 1'b1;
            end
        end
    end

    assign busy           = (state_q != IDLE);
    assign output_spikes  = spk_q;
    assign data_valid_out = dv_q;
    assign debug_output   = v_q[0][V_W-1 -: 8];

endmodule

// File: doc/snn_delay_layer.md
# snn_delay_layer

Parametrised successor to the fixed two-output spiking core: one fully connected layer of leaky integrate-and-fire neurons with per-synapse programmable axonal delays. It has a configurable input and neuron count. Weights, delays, threshold and leak are written through a byte-wide configuration port, normally driven by the SPI slave. One timestep is processed per `input_ready` pulse, and spikes are presented with a `data_valid_out` strobe.

## Interface
- `N_IN`, 4: input spike channels
- `N_OUT`, 2: neurons
- `DELAY_W`, 2: delay field width; delays 0..2^DELAY_W-1 timesteps
- `V_W`, 12: signed membrane width (≥ 9); constraint 2·N_IN·N_OUT+2 ≤ 256
- `clk` in 1: system clock, rising edge
- `reset` in 1: asynchronous, active-high reset
- `cfg_we` in 1: config write strobe
- `cfg_addr` in 8: config address
- `cfg_wdata` in 8: config data
- `input_ready` in 1: start one timestep
- `input_spikes` in N_IN: spikes for this timestep, sampled with `input_ready`
- `busy` out 1: timestep in progress
- `output_spikes` out N_OUT: registered spikes of last completed timestep
- `data_valid_out` out 1: one-cycle strobe, `output_spikes` updated
- `debug_output` out 8: V of neuron 0, bits [V_W-1:V_W-8]

## Operation
- Address map (synapse index s = j·N_IN+i, input i, neuron j):
  - 0..N_IN·N_OUT-1: weight[s], signed 8-bit.
  - N_IN·N_OUT..2·N_IN·N_OUT-1: delay[s], low DELAY_W bits.
  - next address: threshold, unsigned 8-bit.
  - next address: leak_shift, bits [2:0].
  - Higher addresses are ignored.
- Writes are accepted only when `busy`=0 and are ignored otherwise.
- History: `hist[0..2^DELAY_W-1]`, each N_IN bits. `hist[d]` holds the spikes from d timesteps ago.
- Synapse (i,j) contributes weight[s] when `hist[delay[s]][i]`=1.
- FSM states:
  - IDLE: on `input_ready`=1, shift history (`hist[0]`←`input_spikes`, `hist[d]`←`hist[d-1]`). Load `acc[j]` ← V[j] − (leak_shift==0 ? 0 : V[j]>>>leak_shift) for all j. Clear counter s, go to ACCUM.
  - ACCUM: one synapse per cycle, in s order, using the already-shifted history. If contributing, `acc[j]` ← sat(`acc[j]` + sext(weight[s])). After s = N_IN·N_OUT−1, go to FIRE.
  - FIRE: for each j, if `acc[j]` ≥ zext(threshold): spike[j]=1 and V[j]←0. Otherwise spike[j]=0 and V[j]←`acc[j]`. Register `output_spikes`, pulse `data_valid_out`, go to IDLE.
- Saturation: clamp to [−2^(V_W−1), 2^(V_W−1)−1] on every addition.
- Reset values:
  - All V, acc, hist, weights and delays: 0.
  - threshold: 8'h40; leak_shift: 0.
  - `output_spikes`: 0; `data_valid_out`: 0; `busy`: 0; state: IDLE.

## Timing
- Let N = N_IN·N_OUT. `input_ready` is sampled at edge k (IDLE).
- `busy` goes high after edge k.
- ACCUM spans edges k+1..k+N; FIRE executes at edge k+N+1.
- After edge k+N+1: `output_spikes` is valid, `data_valid_out`=1 for exactly one cycle, `busy`=0.
- Default latency: 9 edges.
- `input_ready` while `busy`=1 is dropped; no queuing.
- `input_ready` still high in the first IDLE cycle starts a new timestep, so the producer must pulse it for one cycle.
- `output_spikes` holds its value between FIRE cycles.
- `debug_output` follows V combinationally and changes after FIRE.
- Reset asserted mid-timestep: immediate return to IDLE with all reset values; no `data_valid_out`.
- `cfg_we` in the same cycle as an accepted `input_ready` (IDLE) is applied. The timestep then uses the new value from LOAD onward.

## Test plan
- **Reset:** assert reset mid-ACCUM → after release, `busy`=0, `output_spikes`=0, `debug_output`=0. A read-back timestep with threshold 64 and all weights 0 gives no spikes.
- **Integrate/fire:** weight[0]=50, delay 0, threshold 64; two timesteps with `input_spikes`=4'b0001.
  - Step 1 → `output_spikes`=00, `debug_output`=V0[11:4]=0x03.
  - Step 2 → `output_spikes`=01, V0=0.
  - Each strobe arrives 9 edges after its `input_ready`.
- **Delay:** weight[s=5]=70, delay[5]=3 (input 1 → neuron 1); spike on input 1 at step 1 only, then zeros → `output_spikes[1]`=1 at step 4 only, 0 at steps 1–3 and 5.
- **Leak:** leak_shift=1, weight[0]=40, input 0 spiking every step → V0 = 40, 60, then 70 ≥ 64 fires at step 3.
- **Negative saturation:** weights s=0..3 = −128, all inputs spiking → V0 = −512, −1024, −1536, −2048, then stays −2048 at step 5; `debug_output`=0x80.
- **Busy rules:** second `input_ready` 3 cycles after the first → ignored, exactly one `data_valid_out`. `cfg_we` to threshold during `busy` → ignored, threshold stays 64.
